// File: rtl/layered_txn_gen.sv
// Layered constrained-random transaction generator.
//
// A run is started with `start` while idle. Every cfg_* input is captured on
// that edge. Each GEN cycle builds one candidate from two Galois LFSRs:
//   A (address/kind) -> range offset, alignment, read/write choice
//   D (data)         -> masked/forced data word
// A candidate whose offset falls outside the address range is dropped and GEN
// tries again on the next cycle. An accepted candidate is presented on the
// out_* valid/ready interface and stays there until it is taken. Channels are
// assigned round-robin over the enabled mask.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, stop       begin a run (idle only) / abort a run
//   cfg_*             run configuration, sampled on the accepted start
//   out_valid/ready   transaction handshake
//   out_addr/data/wr/ch  transaction payload
//   busy, done, err   run in progress, end-of-run pulse, sticky config error
//   count             handshakes completed in the current run
module layered_txn_gen #(
  parameter int          ADDR_W = 16,
  parameter int          DATA_W = 32,
  parameter int          NUM_CH = 4,
  parameter logic [31:0] SEED   = 32'h1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic [15:0]               cfg_num_txn,
  input  logic [ADDR_W-1:0]         cfg_addr_min,
  input  logic [ADDR_W-1:0]         cfg_addr_max,
  input  logic [2:0]                cfg_align,
  input  logic [DATA_W-1:0]         cfg_data_mask,
  input  logic [DATA_W-1:0]         cfg_data_force,
  input  logic [7:0]                cfg_wr_weight,
  input  logic [NUM_CH-1:0]         cfg_ch_en,
  input  logic [31:0]               cfg_seed,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_W-1:0]         out_addr,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_wr,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [15:0]               count
);

  localparam int          CH_W      = $clog2(NUM_CH);
  // x^32 + x^22 + x^2 + x + 1 in shift-right Galois form
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    HOLD,
    DONE
  } state_t;

  state_t              state;
  logic [31:0]         lfsr_a;
  logic [31:0]         lfsr_d;
  logic                stop_pend;
  logic [CH_W-1:0]     last_ch;

  logic [15:0]         r_num_txn;
  logic [ADDR_W-1:0]   r_addr_min;
  logic [ADDR_W-1:0]   r_addr_max;
  logic [2:0]          r_align;
  logic [DATA_W-1:0]   r_data_mask;
  logic [DATA_W-1:0]   r_data_force;
  logic [7:0]          r_wr_weight;
  logic [NUM_CH-1:0]   r_ch_en;

  logic [ADDR_W-1:0]   range;
  logic [ADDR_W-1:0]   span_mask;
  logic [ADDR_W-1:0]   off;
  logic [ADDR_W-1:0]   align_keep;
  logic                reject;
  logic [ADDR_W-1:0]   cand_addr;
  logic [DATA_W-1:0]   cand_data;
  logic                cand_wr;
  logic [CH_W-1:0]     ch_hi;
  logic [CH_W-1:0]     ch_lo;
  logic                hi_found;
  logic [CH_W-1:0]     next_ch;
  logic                cfg_err;
  logic                handshake_last;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

  // Layer 1: smear the range down to an all-ones mask so the raw offset has
  // at least a 50% chance of landing inside [0, range].
  always_comb begin
    range     = r_addr_max - r_addr_min;
    span_mask = range;
    for (int unsigned i = 0; i < ADDR_W; i++) begin
      span_mask = span_mask | (span_mask >> 1);
    end
    off    = lfsr_a[ADDR_W-1:0] & span_mask;
    reject = off > range;
  end

  // Layers 2-4. Rounding off down keeps it <= range, so cand_addr <= max.
  always_comb begin
    align_keep = {ADDR_W{1'b1}} << r_align;
    cand_addr  = r_addr_min + (off & align_keep);
    cand_data  = (lfsr_d[DATA_W-1:0] & r_data_mask) | r_data_force;
    cand_wr    = lfsr_a[31:24] < r_wr_weight;
  end

  // Round-robin: lowest enabled channel above last_ch, else lowest enabled
  // overall. last_ch starts at NUM_CH-1 so the first pick is the lowest one.
  always_comb begin
    ch_hi    = '0;
    ch_lo    = '0;
    hi_found = 1'b0;
    for (int unsigned c = NUM_CH; c > 0; c--) begin
      if (r_ch_en[c-1]) begin
        ch_lo = CH_W'(c - 1);
        if (CH_W'(c - 1) > last_ch) begin
          ch_hi    = CH_W'(c - 1);
          hi_found = 1'b1;
        end
      end
    end
    next_ch = hi_found ? ch_hi : ch_lo;
  end

  always_comb begin
    cfg_err = (cfg_addr_max < cfg_addr_min) ||
              (cfg_ch_en == '0) ||
              ((cfg_addr_min & ~({ADDR_W{1'b1}} << cfg_align)) != '0);
    handshake_last = (count + 16'd1) == r_num_txn;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      lfsr_a       <= SEED;
      lfsr_d       <= ~SEED;
      stop_pend    <= 1'b0;
      last_ch      <= CH_W'(NUM_CH - 1);
      r_num_txn    <= '0;
      r_addr_min   <= '0;
      r_addr_max   <= '0;
      r_align      <= '0;
      r_data_mask  <= '0;
      r_data_force <= '0;
      r_wr_weight  <= '0;
      r_ch_en      <= '0;
      out_valid    <= 1'b0;
      out_addr     <= '0;
      out_data     <= '0;
      out_wr       <= 1'b0;
      out_ch       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      count        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            r_num_txn    <= cfg_num_txn;
            r_addr_min   <= cfg_addr_min;
            r_addr_max   <= cfg_addr_max;
            r_align      <= cfg_align;
            r_data_mask  <= cfg_data_mask;
            r_data_force <= cfg_data_force;
            r_wr_weight  <= cfg_wr_weight;
            r_ch_en      <= cfg_ch_en;
            if (cfg_seed != '0) begin
              lfsr_a <= cfg_seed;
              lfsr_d <= ~cfg_seed;
            end
            count     <= '0;
            err       <= cfg_err;
            stop_pend <= 1'b0;
            last_ch   <= CH_W'(NUM_CH - 1);
            if (cfg_err || cfg_num_txn == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= GEN;
              busy  <= 1'b1;
            end
          end
        end

        GEN: begin
          lfsr_a <= lfsr_step(lfsr_a);
          lfsr_d <= lfsr_step(lfsr_d);
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (!reject) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            out_addr  <= cand_addr;
            out_data  <= cand_data;
            out_wr    <= cand_wr;
            out_ch    <= next_ch;
            last_ch   <= next_ch;
          end
        end

        HOLD: begin
          if (stop) stop_pend <= 1'b1;
          if (out_ready) begin
            out_valid <= 1'b0;
            count     <= count + 16'd1;
            if (stop || stop_pend) begin
              state     <= IDLE;
              busy      <= 1'b0;
              stop_pend <= 1'b0;
            end else if (handshake_last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= GEN;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layered_txn_gen.sv
// Bench for layered_txn_gen: a transaction-level model predicts the full
// stream of each run; a negedge monitor compares every valid cycle against it.
module tb_layered_txn_gen;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              stop;
  logic [15:0]       cfg_num_txn;
  logic [ADDR_W-1:0] cfg_addr_min;
  logic [ADDR_W-1:0] cfg_addr_max;
  logic [2:0]        cfg_align;
  logic [DATA_W-1:0] cfg_data_mask;
  logic [DATA_W-1:0] cfg_data_force;
  logic [7:0]        cfg_wr_weight;
  logic [NUM_CH-1:0] cfg_ch_en;
  logic [31:0]       cfg_seed;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_wr;
  logic [CH_W-1:0]   out_ch;
  logic              busy;
  logic              done;
  logic              err;
  logic [15:0]       count;

  layered_txn_gen #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .NUM_CH(NUM_CH),
    .SEED  (32'h1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stop          (stop),
    .cfg_num_txn   (cfg_num_txn),
    .cfg_addr_min  (cfg_addr_min),
    .cfg_addr_max  (cfg_addr_max),
    .cfg_align     (cfg_align),
    .cfg_data_mask (cfg_data_mask),
    .cfg_data_force(cfg_data_force),
    .cfg_wr_weight (cfg_wr_weight),
    .cfg_ch_en     (cfg_ch_en),
    .cfg_seed      (cfg_seed),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_addr      (out_addr),
    .out_data      (out_data),
    .out_wr        (out_wr),
    .out_ch        (out_ch),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wr;
    logic [CH_W-1:0]   ch;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        obs_q[$];
  txn_t        saved_q[$];
  logic [31:0] m_a;
  logic [31:0] m_d;
  int          checks   = 0;
  int          failures = 0;
  int          done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout, want event within budget", name);
  endtask

  // Next state of a 32-bit Galois LFSR for x^32+x^22+x^2+x+1 (shift right).
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] taps;
    taps = (32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1;
    return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
  endfunction

  // Predict the whole transaction stream of one run from the current cfg.
  task automatic model_run();
    int   r, m, off, last, n, c;
    txn_t t;
    if (cfg_seed != 0) begin
      m_a = cfg_seed;
      m_d = ~cfg_seed;
    end
    r = int'(cfg_addr_max) - int'(cfg_addr_min);
    m = 0;
    while (m < r) m = m * 2 + 1;
    last = NUM_CH - 1;
    n    = 0;
    c    = 0;
    while (n < int'(cfg_num_txn)) begin
      off = int'(m_a[15:0]) & m;
      if (off <= r) begin
        t.addr = 16'(int'(cfg_addr_min) + off - (off % (1 << cfg_align)));
        t.data = (m_d & cfg_data_mask) | cfg_data_force;
        t.wr   = (m_a[31:24] < cfg_wr_weight);
        for (int k = 1; k <= NUM_CH; k++) begin
          c = (last + k) % NUM_CH;
          if (cfg_ch_en[c]) break;
        end
        last = c;
        t.ch = 2'(c);
        exp_q.push_back(t);
        n++;
      end
      m_a = lfsr_next(m_a);
      m_d = lfsr_next(m_d);
    end
  endtask

  // Monitor: every valid cycle must show the predicted head transaction.
  always @(negedge clk) begin
    txn_t o;
    if (done) done_cnt++;
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got out_valid=1 addr=0x%0h, want no transaction", out_addr);
      end else begin
        check("txn_addr", 64'(out_addr), 64'(exp_q[0].addr));
        check("txn_data", 64'(out_data), 64'(exp_q[0].data));
        check("txn_wr",   64'(out_wr),   64'(exp_q[0].wr));
        check("txn_ch",   64'(out_ch),   64'(exp_q[0].ch));
        if (out_ready) begin
          o.addr = out_addr;
          o.data = out_data;
          o.wr   = out_wr;
          o.ch   = out_ch;
          obs_q.push_back(o);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    obs_q.delete();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic set_cfg(input logic [15:0] num, input logic [15:0] amin, input logic [15:0] amax,
                         input logic [2:0] algn, input logic [31:0] mask, input logic [31:0] frc,
                         input logic [7:0] wgt, input logic [3:0] en, input logic [31:0] sd);
    cfg_num_txn    = num;
    cfg_addr_min   = amin;
    cfg_addr_max   = amax;
    cfg_align      = algn;
    cfg_data_mask  = mask;
    cfg_data_force = frc;
    cfg_wr_weight  = wgt;
    cfg_ch_en      = en;
    cfg_seed       = sd;
  endtask

  task automatic wait_end(input string name, input int budget, input bit rand_rdy, output int busy_cycles);
    busy_cycles = busy ? 1 : 0;
    for (int i = 0; i < budget; i++) begin
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      tick(1);
      if (busy) busy_cycles++;
      if (!busy && !done) begin
        out_ready = 1'b1;
        return;
      end
    end
    out_ready = 1'b1;
    timeout_fail(name);
  endtask

  task automatic wait_valid(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (out_valid) return;
      tick(1);
    end
    timeout_fail(name);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

  initial begin
    int   bc, bad, d0, stable_bad;
    logic [15:0] a0;
    logic [31:0] dt0;
    logic [15:0] c0;
    logic [1:0]  ch_exp [5];

    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    out_ready = 1'b1;
    set_cfg(16'd0, 16'h0, 16'h0, 3'd0, '0, '0, 8'd0, 4'h0, 32'h0);
    m_a = 32'h1;
    m_d = ~32'h1;
    tick(2);

    // Reset state
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_busy",  64'(busy),      64'd0);
    check("rst_done",  64'(done),      64'd0);
    check("rst_err",   64'(err),       64'd0);
    check("rst_count", 64'(count),     64'd0);
    check("rst_addr",  64'(out_addr),  64'd0);
    check("rst_data",  64'(out_data),  64'd0);
    check("rst_wr",    64'(out_wr),    64'd0);
    check("rst_ch",    64'(out_ch),    64'd0);
    rst_n = 1'b1;
    tick(1);

    // Long ranged run, with latency and cfg-capture checks
    set_cfg(16'd1000, 16'h100, 16'h1FF, 3'd2, 32'hFFFF_FFFF, 32'h0, 8'd128, 4'hF, 32'h1);
    model_run();
    check("model_first_addr", 64'(exp_q[0].addr), 64'h100);
    check("model_first_data", 64'(exp_q[0].data), 64'hFFFF_FFFE);
    d0 = done_cnt;
    do_start();
    check("lat_busy_n1",  64'(busy),      64'd1);
    check("lat_valid_n1", 64'(out_valid), 64'd0);
    set_cfg(16'd3, 16'h0, 16'h0, 3'd0, 32'h0, 32'h0, 8'd0, 4'h1, 32'h77);
    tick(1);
    check("lat_valid_n2", 64'(out_valid), 64'd1);
    wait_end("run1000_end", 3000, 1'b0, bc);
    check("run1000_count", 64'(count), 64'd1000);
    check("run1000_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("run1000_drained", 64'(exp_q.size()), 64'd0);
    check("run1000_obs", 64'(obs_q.size()), 64'd1000);
    bad = 0;
    foreach (obs_q[i])
      if (obs_q[i].addr < 16'h100 || obs_q[i].addr > 16'h1FC || obs_q[i].addr[1:0] != 2'b00) bad++;
    check("run1000_addr_bounds", 64'(bad), 64'd0);
    if (obs_q.size() > 0) begin
      check("run1000_first_addr", 64'(obs_q[0].addr), 64'h100);
      check("run1000_first_data", 64'(obs_q[0].data), 64'hFFFF_FFFE);
      check("run1000_first_wr",   64'(obs_q[0].wr),   64'd1);
      check("run1000_first_ch",   64'(obs_q[0].ch),   64'd0);
    end

    // Single-address range, forced data, seed 0 continues LFSR state
    set_cfg(16'd8, 16'h40, 16'h40, 3'd0, 32'h0, 32'hA5, 8'd100, 4'hF, 32'h0);
    model_run();
    do_start();
    wait_end("single_end", 100, 1'b0, bc);
    check("single_no_stall_busy", 64'(bc), 64'd16);
    bad = 0;
    foreach (obs_q[i]) if (obs_q[i].addr !== 16'h40 || obs_q[i].data !== 32'hA5) bad++;
    check("single_addr_data", 64'(bad), 64'd0);
    check("single_count", 64'(count), 64'd8);

    // Channel round-robin over a sparse mask
    set_cfg(16'd5, 16'h0, 16'hFFF, 3'd1, 32'hFFFF, 32'h0, 8'd200, 4'b1010, 32'h1234_5678);
    model_run();
    do_start();
    wait_end("chan_end", 200, 1'b1, bc);
    ch_exp = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1};
    check("chan_obs", 64'(obs_q.size()), 64'd5);
    bad = 0;
    foreach (obs_q[i]) if (i < 5 && obs_q[i].ch !== ch_exp[i]) bad++;
    check("chan_sequence", 64'(bad), 64'd0);

    // Randomized valid configurations with random backpressure
    for (int r = 0; r < 6; r++) begin
      logic [2:0]  al;
      logic [15:0] mn;
      al = 3'($urandom_range(0, 4));
      mn = 16'($urandom_range(0, 16'h7FFF)) & (16'hFFFF << al);
      set_cfg(16'($urandom_range(1, 40)), mn, mn + 16'($urandom_range(0, 16'h3000)), al,
              $urandom, $urandom & 32'h0F0F_0000, 8'($urandom), 4'($urandom_range(1, 15)),
              ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom | 32'h1));
      model_run();
      d0 = done_cnt;
      do_start();
      wait_end("rand_end", 1500, 1'b1, bc);
      check("rand_count", 64'(count), 64'(cfg_num_txn));
      check("rand_drained", 64'(exp_q.size()), 64'd0);
      check("rand_done_pulses", 64'(done_cnt - d0), 64'd1);
    end

    // Backpressure: payload and count frozen while ready is low
    set_cfg(16'd3, 16'h200, 16'h2FF, 3'd3, 32'hFFFF_FFFF, 32'h0, 8'd128, 4'hF, 32'h0BAD_F00D);
    model_run();
    out_ready = 1'b0;
    do_start();
    wait_valid("bp_valid", 20);
    a0 = out_addr;
    dt0 = out_data;
    c0 = count;
    stable_bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (!out_valid || out_addr !== a0 || out_data !== dt0 || count !== c0) stable_bad++;
    end
    check("bp_stable", 64'(stable_bad), 64'd0);
    check("bp_count_held", 64'(count), 64'd0);
    out_ready = 1'b1;
    wait_end("bp_end", 100, 1'b0, bc);
    check("bp_count_final", 64'(count), 64'd3);

    // Same seed twice gives the same stream; weight 0 gives only reads
    set_cfg(16'd50, 16'h1000, 16'h5FFF, 3'd2, 32'hFFFF_FFFF, 32'h0, 8'd0, 4'hF, 32'hCAFE_BABE);
    model_run();
    do_start();
    wait_end("seed1_end", 1000, 1'b1, bc);
    saved_q = obs_q;
    model_run();
    do_start();
    wait_end("seed2_end", 1000, 1'b1, bc);
    bad = (saved_q.size() == obs_q.size() && obs_q.size() == 50) ? 0 : 1;
    foreach (obs_q[i])
      if (i < saved_q.size() && (obs_q[i].addr !== saved_q[i].addr || obs_q[i].data !== saved_q[i].data ||
          obs_q[i].wr !== saved_q[i].wr || obs_q[i].ch !== saved_q[i].ch)) bad++;
    check("seed_repeat", 64'(bad), 64'd0);
    bad = 0;
    foreach (obs_q[i]) if (obs_q[i].wr !== 1'b0) bad++;
    check("weight0_reads", 64'(bad), 64'd0);

    // Config errors: max < min, no channels, misaligned floor
    set_cfg(16'd4, 16'h300, 16'h200, 3'd0, '1, '0, 8'd1, 4'hF, 32'h0);
    d0 = done_cnt;
    do_start();
    check("err_flag", 64'(err), 64'd1);
    check("err_done_n1", 64'(done), 64'd1);
    check("err_busy", 64'(busy), 64'd0);
    check("err_count_clear", 64'(count), 64'd0);
    tick(3);
    check("err_sticky", 64'(err), 64'd1);
    check("err_done_pulses", 64'(done_cnt - d0), 64'd1);
    set_cfg(16'd4, 16'h100, 16'h200, 3'd0, '1, '0, 8'd1, 4'h0, 32'h0);
    do_start();
    check("err_no_ch", 64'(err), 64'd1);
    tick(2);
    set_cfg(16'd4, 16'h101, 16'h200, 3'd2, '1, '0, 8'd1, 4'hF, 32'h0);
    do_start();
    check("err_misaligned", 64'(err), 64'd1);
    tick(2);

    // Zero-length run: done pulse, error cleared
    set_cfg(16'd0, 16'h100, 16'h200, 3'd2, '1, '0, 8'd1, 4'hF, 32'h0);
    d0 = done_cnt;
    do_start();
    check("zero_err_clear", 64'(err), 64'd0);
    check("zero_done", 64'(done), 64'd1);
    tick(3);
    check("zero_done_pulses", 64'(done_cnt - d0), 64'd1);

    // Stop in HOLD with ready low: finish the pending handshake, no done
    set_cfg(16'd5, 16'h0, 16'hFF, 3'd0, '1, '0, 8'd50, 4'hF, 32'h600D_5EED);
    model_run();
    out_ready = 1'b0;
    d0 = done_cnt;
    do_start();
    wait_valid("stophold_valid", 20);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    tick(2);
    check("stophold_valid_held", 64'(out_valid), 64'd1);
    check("stophold_count_held", 64'(count), 64'd0);
    out_ready = 1'b1;
    tick(1);
    check("stophold_valid_drop", 64'(out_valid), 64'd0);
    check("stophold_busy", 64'(busy), 64'd0);
    check("stophold_count", 64'(count), 64'd1);
    exp_q.delete();
    tick(4);
    check("stophold_no_done", 64'(done_cnt - d0), 64'd0);
    check("stophold_idle", 64'(busy), 64'd0);

    // Stop and start together while idle: stop wins
    stop = 1'b1;
    start = 1'b1;
    tick(1);
    stop = 1'b0;
    start = 1'b0;
    check("stopstart_busy", 64'(busy), 64'd0);
    check("stopstart_done", 64'(done), 64'd0);
    check("stopstart_count_kept", 64'(count), 64'd1);

    // Stop in GEN: back to idle, no transaction, no done
    set_cfg(16'd5, 16'h0, 16'hFF, 3'd0, '1, '0, 8'd50, 4'hF, 32'h55);
    d0 = done_cnt;
    do_start();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("stopgen_busy", 64'(busy), 64'd0);
    check("stopgen_valid", 64'(out_valid), 64'd0);
    tick(4);
    check("stopgen_no_done", 64'(done_cnt - d0), 64'd0);
    check("stopgen_count", 64'(count), 64'd0);

    // Reset mid-run drops valid at once; LFSRs return to SEED
    set_cfg(16'd20, 16'h0, 16'hFF, 3'd0, '1, '0, 8'd50, 4'hF, 32'h0F0F_1234);
    model_run();
    out_ready = 1'b0;
    do_start();
    wait_valid("rstmid_valid", 20);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_valid", 64'(out_valid), 64'd0);
    check("rstmid_busy",  64'(busy),      64'd0);
    check("rstmid_count", 64'(count),     64'd0);
    exp_q.delete();
    m_a = 32'h1;
    m_d = ~32'h1;
    out_ready = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    set_cfg(16'd10, 16'h80, 16'h3FF, 3'd3, '1, 32'h8000_0000, 8'd255, 4'b0111, 32'h0);
    model_run();
    do_start();
    wait_end("post_rst_end", 200, 1'b1, bc);
    check("post_rst_count", 64'(count), 64'd10);
    check("post_rst_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
